// File: rtl/dh_pkg.sv
// Shared definitions for the drone Diffie-Hellman key exchange (initiator and responder).
package dh_pkg;

    // Default group parameters, shared with the initiator's modular exponentiation block
    localparam int unsigned DH_P = 23;
    localparam int unsigned DH_G = 5;
    localparam int unsigned DH_N = 8;

    // Responder control states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PUB  = 3'd2,
        KEY  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } dh_state_e;

    // A peer public value of 0, 1 or anything not reduced mod P is refused
    function automatic logic dh_reject_peer(input int unsigned value, input int unsigned modulus);
        return (value < 2) || (value >= modulus);
    endfunction

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiplier: q = (a * b) % P, full 2N-bit product reduced in one step.
module mod_mul #(
    parameter int unsigned P = 23,
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q
);

    localparam logic [2*N-1:0] MODULUS = (2*N)'(P);

    logic [2*N-1:0] prod;

    // Widen both operands so the product keeps all 2N bits before reduction
    always_comb begin
        prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        q    = N'(prod % MODULUS);
    end

endmodule

// File: rtl/dh_responder.sv
// Responder side of the DH exchange: computes G^priv mod P and peer_pub^priv mod P
// with constant-time square-and-multiply, sharing one modular multiplier.
module dh_responder
    import dh_pkg::*;
#(
    parameter int unsigned P = DH_P,
    parameter int unsigned G = DH_G,
    parameter int unsigned N = DH_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         peer_valid,
    output logic         peer_ready,
    input  logic [N-1:0] peer_pub,
    input  logic [N-1:0] priv,
    output logic [N-1:0] pub_out,
    output logic [N-1:0] key_out,
    output logic         rdy,
    output logic         err,
    output logic         busy
);

    localparam int unsigned  IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);
    localparam logic [N-1:0]  ONE     = N'(1);

    dh_state_e     state_q, state_d;
    logic [N-1:0]  peer_q, peer_d;
    logic [N-1:0]  priv_q, priv_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  base_q, base_d;
    logic [N-1:0]  pub_q, pub_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          mul_phase_q, mul_phase_d;
    logic [N-1:0]  pub_out_q, pub_out_d;
    logic [N-1:0]  key_out_q, key_out_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          peer_ready_q, peer_ready_d;

    logic [N-1:0]  mul_b;
    logic [N-1:0]  mul_q;

    // Square step multiplies acc by itself; multiply step always runs, using 1 when the bit is clear
    always_comb begin
        mul_b = acc_q;
        if (mul_phase_q) begin
            mul_b = priv_q[idx_q] ? base_q : ONE;
        end
    end

    mod_mul #(.P(P), .N(N)) u_mod_mul (
        .a (acc_q),
        .b (mul_b),
        .q (mul_q)
    );

    // Next-state, datapath updates and registered output values
    always_comb begin
        state_d     = state_q;
        peer_d      = peer_q;
        priv_d      = priv_q;
        acc_d       = acc_q;
        base_d      = base_q;
        pub_d       = pub_q;
        idx_d       = idx_q;
        mul_phase_d = mul_phase_q;
        pub_out_d   = pub_out_q;
        key_out_d   = key_out_q;
        rdy_d       = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (peer_valid && peer_ready_q) begin
                    peer_d  = peer_pub;
                    priv_d  = priv;
                    state_d = dh_reject_peer(32'(peer_pub), P) ? ERR : LOAD;
                end
            end
            LOAD: begin
                acc_d       = ONE;
                base_d      = N'(G);
                idx_d       = IDX_TOP;
                mul_phase_d = 1'b0;
                state_d     = PUB;
            end
            PUB, KEY: begin
                acc_d       = mul_q;
                mul_phase_d = !mul_phase_q;
                if (mul_phase_q) begin
                    idx_d = idx_q - 1'b1;
                    if (idx_q == '0) begin
                        if (state_q == PUB) begin
                            pub_d   = mul_q;
                            acc_d   = ONE;
                            base_d  = peer_q;
                            idx_d   = IDX_TOP;
                            state_d = KEY;
                        end else begin
                            pub_out_d = pub_q;
                            key_out_d = mul_q;
                            rdy_d     = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        peer_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    // State and datapath registers; everything holds while ena is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            peer_q       <= '0;
            priv_q       <= '0;
            acc_q        <= '0;
            base_q       <= '0;
            pub_q        <= '0;
            idx_q        <= '0;
            mul_phase_q  <= 1'b0;
            pub_out_q    <= '0;
            key_out_q    <= '0;
            rdy_q        <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            peer_ready_q <= 1'b0;
        end else if (ena) begin
            state_q      <= state_d;
            peer_q       <= peer_d;
            priv_q       <= priv_d;
            acc_q        <= acc_d;
            base_q       <= base_d;
            pub_q        <= pub_d;
            idx_q        <= idx_d;
            mul_phase_q  <= mul_phase_d;
            pub_out_q    <= pub_out_d;
            key_out_q    <= key_out_d;
            rdy_q        <= rdy_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            peer_ready_q <= peer_ready_d;
        end
    end

    assign peer_ready = peer_ready_q;
    assign pub_out    = pub_out_q;
    assign key_out    = key_out_q;
    assign rdy        = rdy_q;
    assign err        = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dh_responder.sv
// Self-checking bench for dh_responder with P=23, G=5, N=8.
module tb_dh_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       peer_valid = 1'b0;
    logic       peer_ready;
    logic [7:0] peer_pub = 8'd0;
    logic [7:0] priv = 8'd0;
    logic [7:0] pub_out;
    logic [7:0] key_out;
    logic       rdy;
    logic       err;
    logic       busy;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] priv;
        logic [7:0] peer;
        logic [7:0] exp_pub;
        logic [7:0] exp_key;
        bit         exp_err;
    } vec_t;

    vec_t vecs[10];

    dh_responder #(.P(23), .G(5), .N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .peer_valid (peer_valid),
        .peer_ready (peer_ready),
        .peer_pub   (peer_pub),
        .priv       (priv),
        .pub_out    (pub_out),
        .key_out    (key_out),
        .rdy        (rdy),
        .err        (err),
        .busy       (busy)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One exchange from acceptance; n counts enabled edges after acceptance (E1 is n=1)
    task automatic applyStimulus(input logic [7:0] p, input logic [7:0] pp, input bit gate_ena,
                                 output int rdy_at, output int rdy_count,
                                 output int err_at, output int err_count);
        int n;
        bit en_now;
        rdy_at = -1;
        err_at = -1;
        rdy_count = 0;
        err_count = 0;
        n = 0;
        @(negedge clk);
        ena = 1'b1;
        priv = p;
        peer_pub = pp;
        peer_valid = 1'b1;
        checkOutput("ready_before_accept", int'(peer_ready), 1);
        @(posedge clk);
        @(negedge clk);
        peer_valid = 1'b0;
        priv = 8'hAA;
        peer_pub = 8'h33;
        for (int cyc = 0; cyc < 150 && n < 40; cyc++) begin
            if (gate_ena && n >= 4 && n < 14) begin
                ena = cyc[0];
            end else begin
                ena = 1'b1;
            end
            en_now = ena;
            @(posedge clk);
            if (en_now) n++;
            @(negedge clk);
            if (rdy) begin
                rdy_count++;
                if (rdy_at < 0) rdy_at = n;
            end
            if (err) begin
                err_count++;
                if (err_at < 0) err_at = n;
            end
        end
        ena = 1'b1;
        checkOutput("cycle_budget", int'(n), 40);
    endtask

    initial begin
        int rdy_at, rdy_count, err_at, err_count;
        int last_pub, last_key;
        int rdy_seen, early_ready;
        int p1, k1, p2, k2;
        bit drop_pending;

        // 5 has order 22 mod 23, so 5^255 = 5^13 = 21; 19^6 = 2; 10^3 = 11; 2^2 = 4
        vecs[0] = '{8'd6,   8'd19,  8'd8,  8'd2,  1'b0};
        vecs[1] = '{8'd0,   8'd19,  8'd1,  8'd1,  1'b0};
        vecs[2] = '{8'd255, 8'd5,   8'd21, 8'd21, 1'b0};
        vecs[3] = '{8'd6,   8'd0,   8'd0,  8'd0,  1'b1};
        vecs[4] = '{8'd6,   8'd1,   8'd0,  8'd0,  1'b1};
        vecs[5] = '{8'd6,   8'd23,  8'd0,  8'd0,  1'b1};
        vecs[6] = '{8'd6,   8'd200, 8'd0,  8'd0,  1'b1};
        vecs[7] = '{8'd1,   8'd22,  8'd5,  8'd22, 1'b0};
        vecs[8] = '{8'd2,   8'd2,   8'd2,  8'd4,  1'b0};
        vecs[9] = '{8'd3,   8'd10,  8'd10, 8'd11, 1'b0};

        // Reset state
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_peer_ready", int'(peer_ready), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_rdy", int'(rdy), 0);
        checkOutput("reset_err", int'(err), 0);
        checkOutput("reset_pub_out", int'(pub_out), 0);
        checkOutput("reset_key_out", int'(key_out), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_peer_ready", int'(peer_ready), 1);

        // Table of exchanges, including rejections that must leave outputs untouched
        last_pub = 0;
        last_key = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].priv, vecs[i].peer, 1'b0, rdy_at, rdy_count, err_at, err_count);
            if (vecs[i].exp_err) begin
                checkOutput($sformatf("v%0d_err_at", i), err_at, 1);
                checkOutput($sformatf("v%0d_err_count", i), err_count, 1);
                checkOutput($sformatf("v%0d_rdy_count", i), rdy_count, 0);
                checkOutput($sformatf("v%0d_pub_held", i), int'(pub_out), last_pub);
                checkOutput($sformatf("v%0d_key_held", i), int'(key_out), last_key);
            end else begin
                checkOutput($sformatf("v%0d_rdy_at", i), rdy_at, 33);
                checkOutput($sformatf("v%0d_rdy_count", i), rdy_count, 1);
                checkOutput($sformatf("v%0d_err_count", i), err_count, 0);
                checkOutput($sformatf("v%0d_pub", i), int'(pub_out), int'(vecs[i].exp_pub));
                checkOutput($sformatf("v%0d_key", i), int'(key_out), int'(vecs[i].exp_key));
                last_pub = int'(vecs[i].exp_pub);
                last_key = int'(vecs[i].exp_key);
            end
            checkOutput($sformatf("v%0d_idle_busy", i), int'(busy), 0);
        end

        // Clock-enable toggling mid-PUB stretches time but not enabled-edge latency
        applyStimulus(8'd6, 8'd19, 1'b1, rdy_at, rdy_count, err_at, err_count);
        checkOutput("gated_rdy_at", rdy_at, 33);
        checkOutput("gated_rdy_count", rdy_count, 1);
        checkOutput("gated_pub", int'(pub_out), 8);
        checkOutput("gated_key", int'(key_out), 2);

        // peer_valid held through a computation with new data: must wait for peer_ready
        @(negedge clk);
        priv = 8'd6;
        peer_pub = 8'd19;
        peer_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        priv = 8'd3;
        peer_pub = 8'd10;
        rdy_seen = 0;
        early_ready = 0;
        drop_pending = 1'b0;
        p1 = -1; k1 = -1; p2 = -1; k2 = -1;
        for (int cyc = 0; cyc < 200 && rdy_seen < 2; cyc++) begin
            if (rdy) begin
                if (rdy_seen == 0) begin
                    p1 = int'(pub_out);
                    k1 = int'(key_out);
                end else begin
                    p2 = int'(pub_out);
                    k2 = int'(key_out);
                end
                rdy_seen++;
            end
            if (peer_ready) begin
                if (rdy_seen == 0) early_ready++;
                else drop_pending = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            if (drop_pending) peer_valid = 1'b0;
        end
        peer_valid = 1'b0;
        checkOutput("busy_no_early_ready", early_ready, 0);
        checkOutput("busy_done_count", rdy_seen, 2);
        checkOutput("busy_first_pub", p1, 8);
        checkOutput("busy_first_key", k1, 2);
        checkOutput("busy_second_pub", p2, 10);
        checkOutput("busy_second_key", k2, 11);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of KEY discards everything
        @(negedge clk);
        priv = 8'd6;
        peer_pub = 8'd19;
        peer_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        peer_valid = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        checkOutput("midkey_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        checkOutput("midkey_reset_peer_ready", int'(peer_ready), 0);
        checkOutput("midkey_reset_busy", int'(busy), 0);
        checkOutput("midkey_reset_rdy", int'(rdy), 0);
        checkOutput("midkey_reset_err", int'(err), 0);
        checkOutput("midkey_reset_pub_out", int'(pub_out), 0);
        checkOutput("midkey_reset_key_out", int'(key_out), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midkey_release_peer_ready", int'(peer_ready), 1);
        checkOutput("midkey_release_busy", int'(busy), 0);

        // A fresh exchange after the aborted one still produces correct results
        applyStimulus(8'd6, 8'd19, 1'b0, rdy_at, rdy_count, err_at, err_count);
        checkOutput("after_reset_rdy_at", rdy_at, 33);
        checkOutput("after_reset_pub", int'(pub_out), 8);
        checkOutput("after_reset_key", int'(key_out), 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
